// File: rtl/regfile_write_scheduler.sv
// Arbitrates the single register-file write port between ALU (A) and load (B)
// writeback, with an anti-starvation age counter for B and a pending-write scoreboard.
module regfile_write_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int AGE_LIMIT  = 3
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          issue_valid,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  input  logic                          req_a_valid,
  input  logic [ADDR_WIDTH-1:0]         req_a_address,
  input  logic [DATA_WIDTH-1:0]         req_a_data,
  output logic                          req_a_ready,
  input  logic                          req_b_valid,
  input  logic [ADDR_WIDTH-1:0]         req_b_address,
  input  logic [DATA_WIDTH-1:0]         req_b_data,
  output logic                          req_b_ready,
  output logic                          rf_write_enable,
  output logic [ADDR_WIDTH-1:0]         rf_write_address,
  output logic [DATA_WIDTH-1:0]         rf_write_data,
  input  logic [ADDR_WIDTH-1:0]         check_address_1,
  input  logic [ADDR_WIDTH-1:0]         check_address_2,
  output logic                          check_busy_1,
  output logic                          check_busy_2,
  output logic [(2**ADDR_WIDTH)-1:0]    busy_vector,
  output logic                          sb_error
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam int AGE_W    = $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  logic [AGE_W-1:0]      age_q, age_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  sb_error_q, sb_error_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;

  logic                  b_aged;
  logic                  xfer_a, xfer_b;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  write_hit;

  // B wins a conflict only once it has been stalled AGE_LIMIT cycles in a row.
  assign b_aged      = (age_q == AGE_MAX);
  assign req_a_ready = req_a_valid & (~req_b_valid | ~b_aged);
  assign req_b_ready = req_b_valid & (~req_a_valid | b_aged);
  assign xfer_a      = req_a_valid & req_a_ready;
  assign xfer_b      = req_b_valid & req_b_ready;
  assign grant_addr  = xfer_b ? req_b_address : req_a_address;
  assign grant_data  = xfer_b ? req_b_data    : req_a_data;
  // Transfers to x0 are accepted but behave as no-ops everywhere downstream.
  assign write_hit   = (xfer_a | xfer_b) && (grant_addr != '0);

  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    age_d      = age_q;
    busy_d     = busy_q;
    sb_error_d = sb_error_q;
    rf_we_d    = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;

    if (!req_b_valid || xfer_b) begin
      age_d = '0;
    end else if (age_q != AGE_MAX) begin
      age_d = age_q + AGE_W'(1);
    end

    if (write_hit) begin
      rf_we_d   = 1'b1;
      rf_addr_d = grant_addr;
      rf_data_d = grant_data;
      busy_d[grant_addr] = 1'b0;
      if (!busy_q[grant_addr]) begin
        sb_error_d = 1'b1;
      end
    end

    // Applied after the clear so a same-cycle issue to the same register keeps it busy.
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset like any other state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      age_q      <= '0;
      busy_q     <= '0;
      sb_error_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      age_q      <= age_d;
      busy_q     <= busy_d;
      sb_error_q <= sb_error_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign rf_write_enable  = rf_we_q;
  assign rf_write_address = rf_addr_q;
  assign rf_write_data    = rf_data_q;
  assign busy_vector      = busy_q;
  assign sb_error         = sb_error_q;
  assign check_busy_1     = busy_q[check_address_1];
  assign check_busy_2     = busy_q[check_address_2];

endmodule
